// File: rtl/branch_ctrl_if.sv
// Branch-controller bundle: pipeline-stage hazard inputs and stall/forward/branch outputs.
interface branch_ctrl_if;
    logic       br_d;
    logic       bne_d;
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       regwrite_e;
    logic       memtoreg_e;
    logic [4:0] a3_e;
    logic       regwrite_m;
    logic       memtoreg_m;
    logic [4:0] a3_m;
    logic       regwrite_w;
    logic [4:0] a3_w;
    logic       beq_zero;
    logic       stall;
    logic       flush_e;
    logic [1:0] fwd_rs_sel;
    logic [1:0] fwd_rt_sel;
    logic       pc_sel;
    logic       stall_err;

    modport master (
        output br_d, bne_d, rs_d, rt_d, regwrite_e, memtoreg_e, a3_e,
               regwrite_m, memtoreg_m, a3_m, regwrite_w, a3_w, beq_zero,
        input  stall, flush_e, fwd_rs_sel, fwd_rt_sel, pc_sel, stall_err
    );

    modport slave (
        input  br_d, bne_d, rs_d, rt_d, regwrite_e, memtoreg_e, a3_e,
               regwrite_m, memtoreg_m, a3_m, regwrite_w, a3_w, beq_zero,
        output stall, flush_e, fwd_rs_sel, fwd_rt_sel, pc_sel, stall_err
    );
endinterface

// File: rtl/branch_ctrl.sv
// D-stage branch hazard, comparator forwarding and pc_sel; stall/fwd/pc_sel are combinational, stall_err is sticky.
// Optional macro BRANCH_STATS_EN adds saturating br_cnt/taken_cnt/stall_cnt outputs.
module branch_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    branch_ctrl_if.slave     bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, STALL1, STALL2} state_t;

    state_t     state;
    logic       err_q;
    logic       stall;
    logic       pc_sel;
    logic [1:0] fwd_rs;
    logic [1:0] fwd_rt;

    // A load in E always has regwrite_e set, so regwrite_e alone covers both cases.
    wire unused_memtoreg_e = bus.memtoreg_e;

    function automatic logic hazard(input logic [4:0] x,
                                    input logic re, input logic [4:0] ae,
                                    input logic lm, input logic rm, input logic [4:0] am);
        return (x != 5'd0) && ((re && ae == x) || (lm && rm && am == x));
    endfunction

    function automatic logic [1:0] fwd(input logic [4:0] x,
                                       input logic rm, input logic lm, input logic [4:0] am,
                                       input logic rw, input logic [4:0] aw);
        if (x == 5'd0)                 return 2'd0;
        else if (rm && !lm && am == x) return 2'd1;
        else if (rw && aw == x)        return 2'd2;
        else                           return 2'd0;
    endfunction

    always_comb begin
        stall  = 1'b0;
        pc_sel = 1'b0;
        fwd_rs = 2'd0;
        fwd_rt = 2'd0;
        if (!reset && bus.br_d) begin
            stall = hazard(bus.rs_d, bus.regwrite_e, bus.a3_e, bus.memtoreg_m, bus.regwrite_m, bus.a3_m)
                  | hazard(bus.rt_d, bus.regwrite_e, bus.a3_e, bus.memtoreg_m, bus.regwrite_m, bus.a3_m);
            fwd_rs = fwd(bus.rs_d, bus.regwrite_m, bus.memtoreg_m, bus.a3_m, bus.regwrite_w, bus.a3_w);
            fwd_rt = fwd(bus.rt_d, bus.regwrite_m, bus.memtoreg_m, bus.a3_m, bus.regwrite_w, bus.a3_w);
            pc_sel = !stall && (bus.beq_zero ^ bus.bne_d);
        end
    end

    assign bus.stall      = stall;
    assign bus.flush_e    = stall;
    assign bus.pc_sel     = pc_sel;
    assign bus.fwd_rs_sel = fwd_rs;
    assign bus.fwd_rt_sel = fwd_rt;
    assign bus.stall_err  = err_q;

    // A third consecutive stall cycle means the pipeline never drained the hazard.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            err_q <= 1'b0;
        end else if (!bus.br_d || !stall) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE:    state <= STALL1;
                STALL1:  state <= STALL2;
                default: begin
                    state <= STALL2;
                    err_q <= 1'b1;
                end
            endcase
        end
    end

`ifdef BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            br_cnt    <= '0;
            taken_cnt <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.br_d && !stall && br_cnt != CNT_MAX) br_cnt    <= br_cnt + 1'b1;
            if (pc_sel && taken_cnt != CNT_MAX)          taken_cnt <= taken_cnt + 1'b1;
            if (stall && stall_cnt != CNT_MAX)           stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning width of each statistics counter.
REQ-002 SHALL have clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL have reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have br_d  input  1  D-stage instruction is a branch.
REQ-005 SHALL have bne_d  input  1  branch type: 0 beq, 1 bne; valid only with br_d.
REQ-006 SHALL have rs_d, rt_d  input  5 each  D-stage source register numbers.
REQ-007 SHALL have regwrite_e, memtoreg_e  input  1 each  E-stage writes a register / is a load.
REQ-008 SHALL have a3_e  input  5  E-stage destination register.
REQ-009 SHALL have regwrite_m, memtoreg_m  input  1 each  M-stage writes a register / is a load.
REQ-010 SHALL have a3_m  input  5  M-stage destination register.
REQ-011 SHALL have regwrite_w  input  1  and a3_w  input  5  W-stage write-back.
REQ-012 SHALL have beq_zero  input  1  comparator output, 1 when both forwarded operands are equal.
REQ-013 SHALL have stall  output  1  freeze PC and IF/ID register.
REQ-014 SHALL have flush_e  output  1  insert bubble into ID/EX register.
REQ-015 SHALL have fwd_rs_sel, fwd_rt_sel  output  2 each  comparator operand source: 0 register file, 1 M-stage ALU result, 2 W-stage result.
REQ-016 SHALL have pc_sel  output  1  branch taken; select branch target.
REQ-017 SHALL have stall_err  output  1  sticky error flag.

Function
REQ-018 Hazard on operand x (rs_d or rt_d) SHALL exist when br_d=1 and x!=0 and any of the following holds: regwrite_e=1 and a3_e==x; memtoreg_m=1 and regwrite_m=1 and a3_m==x.
REQ-019 stall SHALL equal the hazard condition, combinationally; flush_e SHALL equal stall.
REQ-020 fwd_x_sel SHALL be 1 when regwrite_m=1 and memtoreg_m=0 and a3_m==x!=0; else 2 when regwrite_w=1 and a3_w==x!=0; else 0. M SHALL take priority over W.
REQ-021 pc_sel SHALL be 1 only when br_d=1 and stall=0 and (beq_zero XOR bne_d)=1, in the same cycle; the delay slot instruction is never flushed.
REQ-022 FSM states: IDLE, STALL1, STALL2. IDLE->STALL1 on stall=1. STALL1->STALL2 on stall=1. STALL1/STALL2->IDLE on stall=0. STALL2 with stall=1 SHALL set stall_err and hold STALL2.
REQ-023 A load in E feeding a branch SHALL produce exactly 2 stall cycles; an ALU result in E, or a load in M, SHALL produce exactly 1.
REQ-024 br_d=0 SHALL force stall=0, pc_sel=0 and fwd selects to 0, and SHALL return the FSM to IDLE.

Reset
REQ-025 When reset=1 at a clock edge, the FSM SHALL go to IDLE, stall_err SHALL clear to 0, and all counters SHALL clear to 0.
REQ-026 While reset=1, stall, flush_e and pc_sel SHALL be forced to 0; fwd selects SHALL be forced to 0.
REQ-027 A reset asserted mid-stall SHALL abandon the stall; the next cycle after reset deasserts SHALL re-evaluate the hazard from IDLE.

Configuration
REQ-028 With macro BRANCH_STATS_EN defined, the block SHALL add outputs br_cnt, taken_cnt and stall_cnt, each CNT_W bits.
REQ-029 The counters SHALL increment respectively on: br_d=1 and stall=0; pc_sel=1; stall=1.
REQ-030 Each counter SHALL saturate at all-ones.
REQ-031 Without BRANCH_STATS_EN, those ports and registers SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-032 lw $t0 in E, beq $t0,$t1 in D -> stall=1 for 2 cycles, flush_e=1 for both, then fwd_rs_sel=2 and pc_sel=beq_zero.
REQ-033 addu $t0 in E, bne $t1,$t0 in D -> stall=1 for 1 cycle, then fwd_rt_sel=1 and pc_sel=!beq_zero.
REQ-034 a3_e=0 with regwrite_e=1, beq $0,$0 -> stall=0, fwd selects 0, pc_sel=1 when beq_zero=1.
REQ-035 A hazard held for 3 consecutive cycles (forced stimulus) -> stall_err=1 and remains 1 until reset.
REQ-036 reset=1 during STALL1 -> stall=0 that cycle, FSM=IDLE; with BRANCH_STATS_EN, preload counters to all-ones and issue a taken branch -> counters stay all-ones.
